// File: rtl/muacm_in_fifo.sv
// muacm_in_fifo: user-side IN staging FIFO with show-ahead head
// and immediate / idle-timeout flush hints for the data interface.
module muacm_in_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT_W  = 12,
    parameter int TIMEOUT    = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            u_data,
    input  logic                  u_last,
    input  logic                  u_valid,
    output logic                  u_ready,
    input  logic                  u_flush,
    output logic [7:0]            in_data,
    output logic                  in_last,
    output logic                  in_valid,
    input  logic                  in_ready,
    output logic                  in_flush_now,
    output logic                  in_flush_time,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]  ONE_LVL  = (DEPTH_LOG2+1)'(1);
    localparam logic [TIMEOUT_W-1:0] TMO      = TIMEOUT_W'(TIMEOUT);

    logic [8:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [TIMEOUT_W-1:0]  timer;
    logic                  flush_now_q;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic                  flag_set;
    logic                  flag_clr;
    logic [8:0]            head;

    // Handshake decode and show-ahead head presentation
    always_comb begin
        empty         = (level == '0);
        u_ready       = (level != FULL_LVL);
        in_valid      = ~empty;
        push          = u_valid & u_ready;
        pop           = in_valid & in_ready;
        head          = mem[rd_ptr];
        in_data       = in_valid ? head[7:0] : 8'h00;
        in_last       = in_valid & head[8];
        flag_set      = (push & u_last) | (u_flush & (~empty | push));
        flag_clr      = pop & ~push & (level == ONE_LVL);
        in_flush_now  = flush_now_q;
        in_flush_time = (timer == TMO) & ~empty;
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {u_last, u_data};
        end
    end

    // Pointers and fill level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push & ~pop) begin
                level <= level + 1'b1;
            end else if (pop & ~push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Sticky immediate-flush flag; a new set wins over the emptying pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_now_q <= 1'b0;
        end else if (flag_set) begin
            flush_now_q <= 1'b1;
        end else if (flag_clr) begin
            flush_now_q <= 1'b0;
        end
    end

    // Idle timer: restarts on every push, saturates at the timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (push | empty) begin
            timer <= '0;
        end else if (timer != TMO) begin
            timer <= timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_muacm_in_fifo.sv
// tb_muacm_in_fifo: random and directed stimulus against a
// queue-based reference model of the IN staging FIFO.
module tb_muacm_in_fifo;

    localparam int DL   = 4;
    localparam int DEP  = 16;
    localparam int TMO  = 2048;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   u_data = '0;
    logic         u_last = 1'b0;
    logic         u_valid = 1'b0;
    logic         u_ready;
    logic         u_flush = 1'b0;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_valid;
    logic         in_ready = 1'b0;
    logic         in_flush_now;
    logic         in_flush_time;
    logic [DL:0]  level;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] q[$];
    bit         m_flag = 1'b0;
    int         m_idle = 0;

    muacm_in_fifo #(
        .DEPTH_LOG2(DL),
        .TIMEOUT_W(12),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .u_data(u_data),
        .u_last(u_last),
        .u_valid(u_valid),
        .u_ready(u_ready),
        .u_flush(u_flush),
        .in_data(in_data),
        .in_last(in_last),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_flush_now(in_flush_now),
        .in_flush_time(in_flush_time),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = q.size();
        check("level", 32'(level), 32'(n));
        check("u_ready", 32'(u_ready), 32'(n < DEP));
        check("in_valid", 32'(in_valid), 32'(n > 0));
        check("in_data", 32'(in_data), n > 0 ? 32'(q[0][7:0]) : 32'h0);
        check("in_last", 32'(in_last), n > 0 ? 32'(q[0][8]) : 32'h0);
        check("flush_now", 32'(in_flush_now), 32'(m_flag));
        check("flush_time", 32'(in_flush_time),
              32'((m_idle >= TMO) && (n > 0)));
    endtask

    // One clock: check at negedge, drive, let the edge pass, update model.
    task automatic step(input logic v, input logic [7:0] d, input logic l,
                        input logic r, input logic f, output bit pushed);
        int  n;
        bit  pop;
        bit  set;
        bit  clr;
        check_outputs();
        u_valid  = v;
        u_data   = d;
        u_last   = l;
        in_ready = r;
        u_flush  = f;
        n      = q.size();
        pushed = v && (n < DEP);
        pop    = r && (n > 0);
        set    = (pushed && l) || (f && (n != 0 || pushed));
        clr    = pop && !pushed && (n == 1);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (pushed) q.push_back({l, d});
        if (set) m_flag = 1'b1;
        else if (clr) m_flag = 1'b0;
        if (pushed || n == 0) m_idle = 0;
        else m_idle++;
        @(negedge clk);
        u_valid = 1'b0;
        u_flush = 1'b0;
    endtask

    task automatic idle(input int cycles, input logic r);
        bit p;
        for (int i = 0; i < cycles; i++) step(0, 8'h00, 0, r, 0, p);
    endtask

    task automatic put(input logic [7:0] d, input logic l, input logic r);
        bit p;
        step(1, d, l, r, 0, p);
    endtask

    initial begin
        bit p;
        int sent;
        int budget;
        logic v;
        #1;
        check("rst_ready", 32'(u_ready), 32'h1);
        check("rst_valid", 32'(in_valid), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1);

        put(8'h11, 0, 1);
        put(8'h22, 0, 1);
        put(8'h33, 1, 1);
        idle(4, 1);

        for (int i = 0; i < 17; i++) put(8'(i), 0, 0);
        idle(3, 0);
        idle(18, 1);

        sent = 0;
        budget = 0;
        while ((sent < 100 || q.size() != 0) && budget < 3000) begin
            v = (sent < 100) && ($urandom_range(0, 3) != 0);
            step(v, 8'(sent * 7 + 3), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) != 0), 0, p);
            if (p) sent++;
            budget++;
        end
        check("rand_done", 32'(budget < 3000), 32'h1);

        put(8'hA5, 0, 0);
        idle(TMO + 3, 0);
        put(8'h5C, 0, 0);
        idle(40, 0);
        idle(3, 1);

        put(8'h77, 0, 0);
        idle(TMO + 2, 0);
        idle(2, 1);

        step(0, 8'h00, 0, 0, 1, p);
        idle(2, 0);
        put(8'h01, 0, 0);
        put(8'h02, 0, 0);
        step(0, 8'h00, 0, 0, 1, p);
        idle(3, 0);
        idle(4, 1);

        for (int i = 0; i < 5; i++) put(8'hC0 + 8'(i), (i == 2), 0);
        check_outputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(in_valid), 32'h0);
        check("arst_level", 32'(level), 32'h0);
        check("arst_now", 32'(in_flush_now), 32'h0);
        check("arst_time", 32'(in_flush_time), 32'h0);
        check("arst_ready", 32'(u_ready), 32'h1);
        q.delete();
        m_flag = 1'b0;
        m_idle = 0;
        @(negedge clk);
        rst_n = 1'b1;
        put(8'h5A, 0, 0);
        put(8'h5B, 1, 0);
        idle(4, 1);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
